// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory interface: access-size codes as issued
// by the control unit, and the responder FSM states.
package data_mem_responder_pkg;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b010;
    localparam logic [2:0] SZ_WORD = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic logic size_ok(input logic [2:0] code);
        return (code == SZ_BYTE) || (code == SZ_HALF) || (code == SZ_WORD);
    endfunction

    // Size codes double as byte counts, so the mask is just the low `size` lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 word RAM with byte-lane write enables and a registered read port.
// A read and write to the same word in one cycle returns the old contents.
module data_mem_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       be,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
                mem[addr][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request at a time, splits word-crossing
// accesses into two RAM cycles, and returns extended load data.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  memOffset,
    input  logic        unsignedFlag,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    state_t state, state_nx;

    logic [IDX_W-1:0] cap_idx;
    logic [1:0]       cap_off;
    logic [2:0]       cap_size;
    logic             cap_uns, cap_write, cap_err, cap_split;
    logic [31:0]      cap_wdata;
    logic [31:0]      lo_buf, arr_q, rdata_q;
    logic             err_q;

    logic             accept, req_err;
    logic [IDX_W-1:0] arr_addr;
    logic [3:0]       arr_be;
    logic [31:0]      arr_wdata;
    logic [7:0]       be_span;
    logic [63:0]      wdata_span;
    logic [31:0]      load_raw, resp_data;
    logic             unused_addr_hi;

    function automatic logic [31:0] extend_load(input logic [31:0] w,
                                                input logic [2:0]  size,
                                                input logic        uns);
        case (size)
            SZ_BYTE: return uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            SZ_HALF: return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Upper address bits alias onto the RAM.
    assign unused_addr_hi = ^addr[31:IDX_W+2];

    assign req_err = !size_ok(memOffset) || (memRead == memWrite);
    assign accept  = req_valid && req_ready;

    // Lanes and data laid out across two consecutive words: [7:4]/[63:32] is the HI word.
    assign be_span    = {4'b0000, lane_mask(cap_size)} << cap_off;
    assign wdata_span = {32'h0, cap_wdata} << {cap_off, 3'b000};

    assign load_raw  = 32'({(cap_split ? arr_q : 32'h0), (cap_split ? lo_buf : arr_q)}
                           >> {cap_off, 3'b000});
    assign resp_data = (cap_err || cap_write) ? 32'h0 : extend_load(load_raw, cap_size, cap_uns);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        arr_addr   = cap_idx;
        arr_be     = 4'b0000;
        arr_wdata  = wdata_span[31:0];
        case (state)
            ST_IDLE: begin
                req_ready = !rst;
                if (req_valid) state_nx = req_err ? ST_RESP : ST_LO;
            end
            ST_LO: begin
                arr_be   = cap_write ? be_span[3:0] : 4'b0000;
                state_nx = cap_split ? ST_HI : ST_RESP;
            end
            ST_HI: begin
                arr_addr  = cap_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                arr_be    = cap_write ? be_span[7:4] : 4'b0000;
                arr_wdata = wdata_span[63:32];
                state_nx  = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_nx   = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_idx   <= '0;
            cap_off   <= '0;
            cap_size  <= '0;
            cap_uns   <= 1'b0;
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
            cap_split <= 1'b0;
            cap_wdata <= '0;
        end else if (accept) begin
            cap_idx   <= addr[IDX_W+1:2];
            cap_off   <= addr[1:0];
            cap_size  <= req_err ? 3'b000 : memOffset;
            cap_uns   <= unsignedFlag;
            cap_write <= memWrite;
            cap_err   <= req_err;
            cap_split <= !req_err && (({2'b00, addr[1:0]} + {1'b0, memOffset}) > 4'd4);
            cap_wdata <= wdata;
        end
    end

    // The LO word is parked in lo_buf while the HI word is being read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_buf  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_HI) lo_buf <= arr_q;
            if (state == ST_RESP) begin
                rdata_q <= resp_data;
                err_q   <= cap_err;
            end
        end
    end

    assign rdata = (state == ST_RESP) ? resp_data : rdata_q;
    assign err   = (state == ST_RESP) ? cap_err   : err_q;

    data_mem_array #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W)
    ) u_array (
        .clk  (clk),
        .addr (arr_addr),
        .be   (arr_be),
        .wdata(arr_wdata),
        .rdata(arr_q)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a byte-array reference model
// predicts each response, a monitor compares data, error flag and arrival cycle.
module tb_data_mem_responder;

    localparam int DEPTH  = 256;
    localparam int IDX_W  = 8;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  memOffset = 3'b000;
    logic        unsignedFlag = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;

    data_mem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .memOffset   (memOffset),
        .unsignedFlag(unsignedFlag),
        .addr        (addr),
        .wdata       (wdata),
        .resp_valid  (resp_valid),
        .rdata       (rdata),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        e;
        int          due;
        int          id;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] model [NBYTES];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         resp_seen = 0;
    int         nid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            resp_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response", rdata, err);
            end else begin
                mon_e = sb.pop_front();
                if (rdata !== mon_e.data || err !== mon_e.e || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL resp#%0d: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                             mon_e.id, rdata, err, cyc, mon_e.data, mon_e.e, mon_e.due);
                end
            end
        end
    end

    // Reference: memory as a flat little-endian byte array, aliased modulo its size.
    function automatic void model_req(input logic rd, input logic wr, input logic [2:0] sz,
                                      input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                      output logic [31:0] d, output logic e, output int lat);
        int n;
        logic [31:0] v;
        d = 32'h0;
        e = !(sz == 3'd1 || sz == 3'd2 || sz == 3'd4) || (rd == wr);
        lat = 1;
        if (e) return;
        n = int'(sz);
        lat = (int'(a % 4) + n > 4) ? 3 : 2;
        if (wr) begin
            for (int i = 0; i < n; i++) model[(a + i) % NBYTES] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = model[(a + i) % NBYTES];
            if (!uns && n < 4 && v[8*n-1]) begin
                for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
            end
            d = v;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit track);
        exp_t x;
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready=0 for 50 cycles, required 1");
            return;
        end
        memRead = rd; memWrite = wr; memOffset = sz; unsignedFlag = uns;
        addr = a; wdata = wd; req_valid = 1'b1;
        if (track) begin
            model_req(rd, wr, sz, uns, a, wd, x.data, x.e, x.due);
            x.due = cyc + x.due;
            x.id  = nid++;
            sb.push_back(x);
        end
        @(negedge clk);
        req_valid = 1'b0;
        memRead = 1'($urandom); memWrite = 1'($urandom); memOffset = 3'($urandom);
        unsignedFlag = 1'($urandom); addr = $urandom; wdata = $urandom;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int seen0;
        // Reset state
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

        for (int w = 0; w < DEPTH; w++) issue(1'b0, 1'b1, 3'd4, 1'b0, 32'(4 * w), $urandom, 1'b1);

        // Aligned word, then sub-word sign/zero extension
        issue(1'b0, 1'b1, 3'd4, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd1, 1'b0, 32'h13, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd1, 1'b1, 32'h13, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd2, 1'b0, 32'h12, 32'h0, 1'b1);

        // Word-crossing half store and reload
        issue(1'b0, 1'b1, 3'd2, 1'b0, 32'h17, 32'hFFFF1234, 1'b1);
        issue(1'b1, 1'b0, 3'd2, 1'b1, 32'h17, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h14, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h18, 32'h0, 1'b1);

        // Wrap from the last word to word 0
        issue(1'b0, 1'b1, 3'd4, 1'b0, 32'h3FE, 32'hA1B2C3D4, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h3FE, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h3FC, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h0, 32'h0, 1'b1);

        // Malformed requests
        issue(1'b1, 1'b0, 3'b011, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b1, 1'b1, 3'd4, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 3'b011, 1'b0, 32'h10, 32'h55555555, 1'b1);
        issue(1'b0, 1'b0, 3'd1, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b1);
        drain();

        // Reset during the HI half of a split store
        seen0 = resp_seen;
        issue(1'b0, 1'b1, 3'd4, 1'b0, 32'h0E, 32'h99887766, 1'b0);
        model[32'h0E] = 8'h66;
        model[32'h0F] = 8'h77;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("midrst_req_ready_hold", {31'h0, req_ready}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_release", {31'h0, req_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("midrst_no_resp", 32'(resp_seen - seen0), 32'h0);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h0C, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd4, 1'b0, 32'h10, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'd2, 1'b0, 32'h0E, 32'h0, 1'b1);

        // Randomized mix including aliased addresses and malformed requests
        for (int k = 0; k < 400; k++) begin
            logic       rd, wr;
            logic [2:0] sz;
            int         r;
            r  = $urandom_range(0, 15);
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if (r == 0) wr = rd;
            case ($urandom_range(0, 2))
                0:       sz = 3'd1;
                1:       sz = 3'd2;
                default: sz = 3'd4;
            endcase
            if (r == 1) sz = 3'($urandom_range(0, 7));
            issue(rd, wr, sz, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the load/store control signals the control unit issues: `memRead`, `memWrite`, `memOffset` (byte/half/word), `unsignedFlag`.
- Accepts one request at a time over a valid/ready handshake and owns a byte-lane-writable word RAM.
- Splits misaligned accesses that cross a word boundary into two word accesses.
- Returns sign- or zero-extended load data with a one-cycle response pulse.
- Sits between the execute stage (address from ALU, store data from rs2) and the write-back mux.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM (power of two).
- IDX_W, 8, word-index width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- memRead  input  1  load request.
- memWrite  input  1  store request.
- memOffset  input  3  access size: 001=byte, 010=half, 100=word.
- unsignedFlag  input  1  zero-extend the load result when 1, sign-extend when 0.
- addr  input  32  byte address.
- wdata  input  32  store data, low bytes significant.
- resp_valid  output  1  single-cycle response pulse.
- rdata  output  32  extended load data; 0 for stores and errors.
- err  output  1  qualified by resp_valid; malformed request.

Behaviour:
- Reset and handshake
  - One clock; reset is asynchronous and active-high on clk/rst.
  - During reset: state=IDLE, req_ready=0, resp_valid=0, rdata=0, err=0, capture registers cleared. RAM contents are not reset.
  - req_ready=1 only in IDLE and not in reset. A request is accepted in cycle T when req_valid && req_ready. All inputs are captured at T and may change afterwards.
- Decode at acceptance
  - idx = addr[IDX_W+1:2]; higher address bits are ignored (RAM aliases).
  - off = addr[1:0]; size = 1, 2 or 4 bytes from memOffset.
  - Error when any of: memOffset is not 001/010/100; memRead==memWrite (both set or neither).
  - split = !error && (off + size > 4).
- FSM states: IDLE, LO, HI, RESP.
  - IDLE -> RESP on an erroneous request; the response appears at T+1.
  - IDLE -> LO on a valid request.
  - LO -> HI if split, else LO -> RESP.
  - HI -> RESP.
  - RESP -> IDLE unconditionally.
- Latency (resp_valid timing)
  - Aligned / non-crossing access: resp_valid at T+2.
  - Split access: resp_valid at T+3.
  - Error: resp_valid at T+1.
  - The earliest next acceptance is the cycle after RESP.
- Store
  - In LO, write byte lanes off..min(off+size-1,3) of word idx with wdata bytes 0.. in order.
  - In HI, write the remaining bytes to lanes 0.. of word (idx+1) mod DEPTH; wrap from DEPTH-1 to 0 is required.
  - Unwritten lanes are untouched.
  - Response: rdata=0, err=0.
- Load
  - Synchronous RAM read: LO reads word idx into lo_buf; HI reads word (idx+1) mod DEPTH into hi_buf.
  - In RESP, form {hi_buf, lo_buf} >> (8*off) and keep `size` bytes (hi_buf is 0 if not split).
  - Extend bit 8*size-1 when unsignedFlag=0; zero-extend when 1. unsignedFlag is ignored for word loads.
- Outputs outside RESP: resp_valid=0; rdata and err hold their last RESP values.
- Error response: rdata=0, err=1, no RAM access.
- Reset mid-operation: FSM returns to IDLE, no response is produced. Any store lanes already written in LO persist; the HI half of an interrupted split store is not written.
- req_valid asserted while req_ready=0 is ignored and not queued; the requester must hold it.

Decomposition:
- Shared constants (size encodings 001/010/100, FSM state codes) go in the common `defines.v` beside the control-unit encodings, so both ends of the interface use one definition.
- One sub-module, data_mem_array:
  - DEPTH x 32 RAM with a 4-bit byte-lane write enable and synchronous registered read.
  - Read and write to the same address in the same cycle returns old data.
- The FSM, lane/shift arithmetic and extension stay in data_mem_responder.

Test Plan:
- Word store/load aligned: SW wdata=0xDEADBEEF addr=0x10 → resp at T+2, err=0. Then LW addr=0x10 → rdata=0xDEADBEEF at T+2.
- Byte load sign/zero: after the previous store, LB addr=0x13 → 0xFFFFFFDE; LBU addr=0x13 → 0x000000DE; LH addr=0x12 → 0xFFFFDEAD.
- Split half store crossing a word: SH wdata=0x1234 addr=0x17 → word 5 byte3=0x34, word 6 byte0=0x12, other lanes unchanged, resp at T+3. LHU addr=0x17 → 0x00001234.
- Wrap at top of RAM: SW wdata=0xA1B2C3D4 addr=4*DEPTH-2 (0x3FE) → word 255 lanes 2,3 = D4,C3; word 0 lanes 0,1 = B2,A1. LW at the same address → 0xA1B2C3D4.
- Errors: memOffset=011 with memRead=1 → resp at T+1, err=1, rdata=0, RAM unchanged. memRead=memWrite=1 → same response.
- Reset mid-split: SW addr=0x0E, assert rst during HI → no resp_valid. Word 3 lanes 2,3 written, word 4 unchanged. req_ready=0 while rst is high and returns to 1 the cycle after release.
